// File: rtl/note_lane_if.sv
// Bundle of load, playback and judgement signals for note_lane_shifter.
// song_wrap exists only when NOTE_LANE_LOOP_EN is defined.
interface note_lane_if #(
  parameter int LANES   = 3,
  parameter int DEPTH   = 100,
  parameter int VISIBLE = 27
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                     load_start;
  logic                     wr_valid;
  logic [LANES-1:0]         wr_col;
  logic                     wr_ready;
  logic                     start;
  logic                     step;
  logic [LANES-1:0]         hit;
  logic [LANES*VISIBLE-1:0] lane_window;
  logic [LANES-1:0]         hit_good;
  logic [LANES-1:0]         hit_bad;
  logic [LANES-1:0]         pass_miss;
  logic                     running;
  logic                     done;
  logic [CW-1:0]            song_len;
`ifdef NOTE_LANE_LOOP_EN
  logic                     song_wrap;
`endif

  modport master (
`ifdef NOTE_LANE_LOOP_EN
    input  song_wrap,
`endif
    output load_start, wr_valid, wr_col, start, step, hit,
    input  wr_ready, lane_window, hit_good, hit_bad, pass_miss, running, done, song_len
  );

  modport slave (
`ifdef NOTE_LANE_LOOP_EN
    output song_wrap,
`endif
    input  load_start, wr_valid, wr_col, start, step, hit,
    output wr_ready, lane_window, hit_good, hit_bad, pass_miss, running, done, song_len
  );
endinterface

// File: rtl/note_lane_shifter.sv
// Runtime-loaded note chart shifter with IDLE/LOAD/RUN/DONE control and per-lane hit judgement.
// NOTE_LANE_LOOP_EN: chart rotates in RUN instead of zero-filling, song_wrap pulses on each wrap.
module note_lane_shifter #(
  parameter int LANES   = 3,
  parameter int DEPTH   = 100,
  parameter int VISIBLE = 27
) (
  input  logic     clk,
  input  logic     reset,
  note_lane_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [LANES-1:0][DEPTH-1:0]  store_q, store_d;
  logic [CW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                step_cnt_q, step_cnt_d;
  logic [LANES-1:0]             head_hit_q, head_hit_d;
  logic [LANES-1:0]             hit_good_q, hit_good_d;
  logic [LANES-1:0]             hit_bad_q, hit_bad_d;
  logic [LANES-1:0]             pass_miss_q, pass_miss_d;
  logic                         running_q, running_d;
  logic                         done_q, done_d;
`ifdef NOTE_LANE_LOOP_EN
  logic                         song_wrap_q, song_wrap_d;
  logic [CW-1:0]                last_idx;
`endif
  logic                         wr_fire;
  logic [CW-1:0]                step_nxt;
  logic [LANES*VISIBLE-1:0]     window;

  assign bus.wr_ready = (state_q == LOAD) && (wr_ptr_q < DEPTH_C);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign step_nxt     = step_cnt_q + 1'b1;
`ifdef NOTE_LANE_LOOP_EN
  assign last_idx     = wr_ptr_q - 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    wr_ptr_d    = wr_ptr_q;
    step_cnt_d  = step_cnt_q;
    head_hit_d  = head_hit_q;
    hit_good_d  = '0;
    hit_bad_d   = '0;
    pass_miss_d = '0;
`ifdef NOTE_LANE_LOOP_EN
    song_wrap_d = 1'b0;
`endif
    case (state_q)
      LOAD: begin
        if (wr_fire) begin
          for (int l = 0; l < LANES; l++) store_d[l][wr_ptr_q[AW-1:0]] = bus.wr_col[l];
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (bus.start) state_d = (wr_ptr_d != '0) ? RUN : DONE;
      end
      RUN: begin
        // Hits are judged against the pre-shift head, so a same-cycle hit pre-empts the miss.
        for (int l = 0; l < LANES; l++) begin
          hit_good_d[l]  = bus.hit[l] && store_q[l][0] && !head_hit_q[l];
          hit_bad_d[l]   = bus.hit[l] && !store_q[l][0];
          pass_miss_d[l] = bus.step && store_q[l][0] && !head_hit_q[l] && !bus.hit[l];
        end
        if (bus.step) begin
          head_hit_d = '0;
          for (int l = 0; l < LANES; l++) begin
            store_d[l] = store_q[l] >> 1;
`ifdef NOTE_LANE_LOOP_EN
            store_d[l][last_idx[AW-1:0]] = store_q[l][0];
`endif
          end
          step_cnt_d = step_nxt;
          if (step_nxt == wr_ptr_q) begin
`ifdef NOTE_LANE_LOOP_EN
            step_cnt_d  = '0;
            song_wrap_d = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end else begin
          head_hit_d = head_hit_q | hit_good_d;
        end
      end
      default: ;
    endcase
    // load_start wins in every state: restart loading from an empty chart.
    if (bus.load_start) begin
      state_d     = LOAD;
      store_d     = '0;
      wr_ptr_d    = '0;
      step_cnt_d  = '0;
      head_hit_d  = '0;
      hit_good_d  = '0;
      hit_bad_d   = '0;
      pass_miss_d = '0;
`ifdef NOTE_LANE_LOOP_EN
      song_wrap_d = 1'b0;
`endif
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      store_q     <= '0;
      wr_ptr_q    <= '0;
      step_cnt_q  <= '0;
      head_hit_q  <= '0;
      hit_good_q  <= '0;
      hit_bad_q   <= '0;
      pass_miss_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef NOTE_LANE_LOOP_EN
      song_wrap_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      wr_ptr_q    <= wr_ptr_d;
      step_cnt_q  <= step_cnt_d;
      head_hit_q  <= head_hit_d;
      hit_good_q  <= hit_good_d;
      hit_bad_q   <= hit_bad_d;
      pass_miss_q <= pass_miss_d;
      running_q   <= running_d;
      done_q      <= done_d;
`ifdef NOTE_LANE_LOOP_EN
      song_wrap_q <= song_wrap_d;
`endif
    end
  end

  // Head (index 0) lands on the top bit of each lane slice.
  always_comb begin
    window = '0;
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < VISIBLE; k++)
        window[l*VISIBLE + VISIBLE-1-k] = store_q[l][k];
  end

  assign bus.lane_window = window;
  assign bus.hit_good    = hit_good_q;
  assign bus.hit_bad     = hit_bad_q;
  assign bus.pass_miss   = pass_miss_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.song_len    = wr_ptr_q;
`ifdef NOTE_LANE_LOOP_EN
  assign bus.song_wrap   = song_wrap_q;
`endif
endmodule

// File: doc/note_lane_shifter.md
# note_lane_shifter

Parametrised note-chart shifter for the rhythm game. It replaces the fixed three-lane, 100-bit, reset-preloaded shift registers with the following:
- a runtime column-load port;
- a start/run/done control FSM;
- a song-length counter;
- per-lane hit judgement at the judge line.

It sits between the song-speed rate divider (source of `step`) and the square-drawing/animation and scoring logic, which consume `lane_window`, `hit_good`, `hit_bad` and `pass_miss`.

## Interface
- `LANES`, 3, number of note lanes (red, yellow, blue = 2, 1, 0).
- `DEPTH`, 100, maximum song length in columns (storage per lane).
- `VISIBLE`, 27, columns exported for drawing; must satisfy VISIBLE ≤ DEPTH.

- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: asynchronous, active-high; clears all state.
- `load_start` in 1: enter LOAD; clears storage and length.
- `wr_valid` in 1: column write request.
- `wr_col` in LANES: one chart column; bit l = note present in lane l.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`.
- `start` in 1: begin playback.
- `step` in 1: single-cycle advance pulse from the song-speed divider.
- `hit` in LANES: single-cycle key-press pulses, already edge-detected.
- `lane_window` out LANES*VISIBLE: lane l occupies `[l*VISIBLE +: VISIBLE]`; bit VISIBLE-1 of each slice is the judge-line (head) column.
- `hit_good` out LANES: registered pulse; a note at the head was hit.
- `hit_bad` out LANES: registered pulse; hit with no note at the head.
- `pass_miss` out LANES: registered pulse; a head note left unhit.
- `running` out 1: FSM in RUN.
- `done` out 1: FSM in DONE.
- `song_len` out clog2(DEPTH+1): number of columns loaded.

## Operation
Storage, per lane:
- DEPTH bits; index 0 is the head.
- `lane_window` slice bit VISIBLE-1-k = storage index k.

FSM states and transitions:
- **IDLE**: reset state.
  - `load_start` → LOAD.
- **LOAD**: storage cleared and wr_ptr = 0 on entry.
  - Each accepted write stores `wr_col` at index wr_ptr and increments wr_ptr; `song_len` = wr_ptr.
  - `wr_ready` = (state == LOAD) && (wr_ptr < DEPTH).
  - `start`: → RUN if song_len > 0, else → DONE.
  - `load_start` → restart LOAD, clearing storage again.
- **RUN**:
  - On `step`: every lane shifts one column toward the head; index DEPTH-1 fills with 0.
  - The step counter increments on each step; after song_len steps → DONE.
  - `load_start` aborts → LOAD.
- **DONE**:
  - `load_start` → LOAD.
  - `start` is ignored.

Judgement, per lane:
- Applies in RUN only; no judgement outputs in other states.
- A `head_hit[l]` flag is cleared on every step.
- `hit[l]` with head note set and `head_hit[l]` clear → `hit_good[l]`, and `head_hit[l]` is set.
- `hit[l]` with head note set and `head_hit[l]` already set → ignored; no pulse.
- `hit[l]` with head empty → `hit_bad[l]`.
- `step` with head note set and `head_hit[l]` clear → `pass_miss[l]`.

Judgement rules:
- Storage is never modified by judgement.
- When `hit` and `step` occur in the same cycle, the hit is judged against the pre-shift head, before `pass_miss` is evaluated. A same-cycle hit therefore gives `hit_good` and no `pass_miss`.
- `wr_valid`, `start` and `step` are ignored in states where they are not listed above.

## Timing
Reset values:
- All outputs 0, except `wr_ready` = 0.
- State IDLE; storage, wr_ptr, song_len, step counter and head_hit all 0.

Latencies:
- A write accepted in cycle n is visible in `song_len` at n+1.
- `step` in cycle n updates `lane_window` and `pass_miss` at n+1.
- `hit` in cycle n gives `hit_good`/`hit_bad` at n+1, each high for exactly one cycle.
- `running`/`done` are registered, valid one cycle after the transition-triggering input.
- On the final step, `done` rises at n+1, together with the last `pass_miss`.

Width rules:
- Counters are clog2(DEPTH+1) bits with no wrap. wr_ptr saturates at DEPTH.

## Configuration
`NOTE_LANE_LOOP_EN`, when defined:
- On `step` in RUN, the head column re-enters at index song_len-1 instead of 0 fill. The chart rotates intact.
- The step counter wraps to 0 at song_len; DONE is never reached from RUN.
- An extra output `song_wrap` (1 bit, registered) pulses for one cycle on each wrap.

When undefined:
- Zero fill and the DONE transition apply as described above.
- `song_wrap` does not exist.

## Test plan
All scenarios use LANES=3, DEPTH=8, VISIBLE=4.
- Load and run: load columns 3'b001, 3'b010, 3'b100, start, apply 3 steps. Before stepping, `lane_window` lane0 = 4'b1000, lane1 = 4'b0100, lane2 = 4'b0010; `done` = 1 one cycle after the third step.
- Load capacity: 9 writes with `wr_valid` held → `wr_ready` drops after 8, `song_len` = 8, and the 9th write is dropped.
- Judgement: load 3'b001, start, then:
  - `hit` = 3'b001 → `hit_good` = 3'b001;
  - second `hit` = 3'b001 → no pulse;
  - `hit` = 3'b010 → `hit_bad` = 3'b010;
  - step → `pass_miss` = 0.
- Same-cycle `hit` and `step` on an unhit head note → `hit_good` pulse, no `pass_miss`. Separately, step with no hit → `pass_miss` = 3'b001.
- Reset asserted mid-RUN → all outputs 0 and state IDLE immediately (asynchronous); `start` is then ignored until a new load.
- With `NOTE_LANE_LOOP_EN`: load 2 columns, start, apply 4 steps → head pattern repeats with period 2; `song_wrap` pulses after steps 2 and 4; `done` stays 0.
